ras_ckpt_stack: RTL and testbench
=================================

Name: ras_ckpt_stack

Overview:
- Parametrised return-address stack (RAS) for the frontend branch predictor, sized by the RASDepth and XLEN configuration fields.
- Adds what the fixed-depth RAS lacks: circular overflow, combined push+pop, and up to NR_CKPT speculative checkpoints. A checkpoint is taken per predicted branch and repaired on mispredict.
- Sits between the branch-prediction logic and the PC-gen stage.

Parameters:
- DEPTH, 2, number of stack entries (>=1).
- VLEN, 64, return-address width.
- NR_CKPT, 4, outstanding checkpoints (power of 2, >=2).
- CW, $clog2(NR_CKPT), checkpoint-ID width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  clear stack and all checkpoints.
- push_i  in  1  push data_i (call).
- pop_i  in  1  pop top (return).
- data_i  in  VLEN  return address to push.
- data_o  out  VLEN  current top entry.
- valid_o  out  1  stack non-empty.
- ckpt_i  in  1  take checkpoint this cycle.
- ckpt_id_o  out  CW  ID assigned to a checkpoint taken this cycle.
- ckpt_full_o  out  1  no free checkpoint slot.
- restore_i  in  1  restore from checkpoint restore_id_i.
- restore_id_i  in  CW  checkpoint to restore.
- release_i  in  1  free the oldest checkpoint (branch resolved correctly).

Behaviour:
- Reset (async, rst_ni low):
  - Stack state: tos=0, count=0, all entries 0.
  - Checkpoint FIFO: head=tail=0, ckpt_cnt=0.
  - Outputs: data_o=0, valid_o=0, ckpt_id_o=0, ckpt_full_o=0.
- Stack is circular storage mem[DEPTH], top pointer tos, occupancy count (0..DEPTH).
- Outputs are combinational from registered state; zero latency:
  - data_o = mem[tos].
  - valid_o = (count != 0).
- Push only:
  - tos = tos+1 mod DEPTH; mem[new tos] = data_i.
  - count saturates at DEPTH; at full, the oldest entry is silently overwritten.
- Pop only:
  - If count != 0: tos = tos-1 mod DEPTH, count-1.
  - If count == 0: no state change (underflow ignored).
- Push and pop together: mem[tos] = data_i; tos and count unchanged. If count was 0, count becomes 1.
- Checkpoint:
  - Each slot stores {tos, count, mem[tos]}, captured from state before this cycle's push/pop.
  - ckpt_id_o = tail. If ckpt_i && !ckpt_full_o: slot[tail] written, tail+1, ckpt_cnt+1.
  - ckpt_i while full: ignored.
  - ckpt_full_o = (ckpt_cnt == NR_CKPT).
- Restore (restore_i):
  - tos and count are loaded from slot[restore_id_i], and mem[saved tos] is rewritten with the saved top value.
  - Same-cycle push/pop/ckpt are discarded.
  - The restored checkpoint and all younger ones are freed: tail = restore_id_i, ckpt_cnt = (restore_id_i - head) mod NR_CKPT.
  - restore_id_i must name a live checkpoint; anything else is illegal.
- Release: if ckpt_cnt != 0, head+1 and ckpt_cnt-1. Release on empty is ignored.
- Release with ckpt in the same cycle: both are applied and ckpt_cnt is unchanged. This is allowed even when full.
- Release with restore in the same cycle: release is applied first (head+1).
  - restore_id_i equal to the released head is illegal.
  - ckpt_cnt = (restore_id_i - (head+1)) mod NR_CKPT.
- Priority: flush_i > restore_i > {push, pop, ckpt}.
  - flush_i zeroes count, tos and the checkpoint FIFO. Entry contents are kept.

Optional Feature:
- Macro RAS_CKPT_STATS_EN.
- When defined, adds ports:
  - ovf_cnt_o (out, 16): counts pushes that overwrote an entry while count==DEPTH.
  - unf_cnt_o (out, 16): counts pops ignored at count==0.
- Both counters saturate at 16'hFFFF, reset to 0, and are cleared by flush_i.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- DEPTH=2: push A, push B, push C -> data_o=C; pop -> data_o=B; pop -> valid_o=0 (A overwritten); stats ovf_cnt_o=1.
- Empty stack: pop -> valid_o=0, no state change, unf_cnt_o=1; push+pop with data_i=D in one cycle -> data_o=D, valid_o=1.
- Push A, ckpt (id 0), pop, push X -> data_o=X; restore id 0 -> data_o=A, count=1, ckpt_cnt=0.
- NR_CKPT=4: four ckpt -> ckpt_full_o=1, 5th ignored; release+ckpt in the same cycle -> ckpt_full_o stays 1, new id=0 (wrapped).
- Ckpt ids 0,1,2, then restore id 1 with push asserted -> push discarded, tail=1, ckpt_cnt=1; release -> ckpt_cnt=0.
- rst_ni low mid-operation with 2 entries and 3 checkpoints -> all outputs 0 immediately (async); same for flush_i except entry data retained.

Source files
------------

// File: rtl/ras_ckpt_stack.sv
// ras_ckpt_stack
// Return-address stack for the frontend branch predictor. It has circular
// overflow, a combined push+pop (replace top), and a FIFO of speculative
// checkpoints that is used to repair the stack after a mispredict.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          clear stack pointers and all checkpoints (entry data kept)
//   push_i, data_i   push a return address (call)
//   pop_i            pop the top entry (return)
//   data_o, valid_o  current top entry / stack non-empty
//   ckpt_i           take a checkpoint this cycle
//   ckpt_id_o        ID that a checkpoint taken this cycle receives
//   ckpt_full_o      no free checkpoint slot
//   restore_i        restore the stack from checkpoint restore_id_i
//   restore_id_i     checkpoint to restore; frees it and all younger ones
//   release_i        free the oldest checkpoint (branch resolved correctly)
//
// Optional feature (macro RAS_CKPT_STATS_EN) adds:
//   ovf_cnt_o        saturating count of pushes that overwrote the oldest entry
//   unf_cnt_o        saturating count of pops ignored on an empty stack
module ras_ckpt_stack #(
  parameter  int unsigned DEPTH   = 2,
  parameter  int unsigned VLEN    = 64,
  parameter  int unsigned NR_CKPT = 4,
  localparam int unsigned CW      = $clog2(NR_CKPT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic [VLEN-1:0] data_o,
  output logic            valid_o,
  input  logic            ckpt_i,
  output logic [CW-1:0]   ckpt_id_o,
  output logic            ckpt_full_o,
`ifdef RAS_CKPT_STATS_EN
  output logic [15:0]     ovf_cnt_o,
  output logic [15:0]     unf_cnt_o,
`endif
  input  logic            restore_i,
  input  logic [CW-1:0]   restore_id_i,
  input  logic            release_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 1);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [VLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   tos_q, tos_d;
  logic [NW-1:0]   cnt_q, cnt_d;

  logic [PW-1:0]   slot_tos_q [NR_CKPT];
  logic [PW-1:0]   slot_tos_d [NR_CKPT];
  logic [NW-1:0]   slot_cnt_q [NR_CKPT];
  logic [NW-1:0]   slot_cnt_d [NR_CKPT];
  logic [VLEN-1:0] slot_top_q [NR_CKPT];
  logic [VLEN-1:0] slot_top_d [NR_CKPT];

  logic [CW-1:0]   head_q, head_d;
  logic [CW-1:0]   tail_q, tail_d;
  logic [CW:0]     ckpt_cnt_q, ckpt_cnt_d;

`ifdef RAS_CKPT_STATS_EN
  logic [15:0]     ovf_q, ovf_d;
  logic [15:0]     unf_q, unf_d;
`endif

  logic [PW-1:0]   tos_inc;
  logic [PW-1:0]   tos_dec;
  logic            stack_full;
  logic            ckpt_full;
  logic            rel_ok;
  logic            ckpt_ok;
  logic [CW-1:0]   head_rel;

  assign data_o      = mem_q[tos_q];
  assign valid_o     = (cnt_q != '0);
  assign ckpt_id_o   = tail_q;
  assign ckpt_full_o = ckpt_full;
`ifdef RAS_CKPT_STATS_EN
  assign ovf_cnt_o   = ovf_q;
  assign unf_cnt_o   = unf_q;
`endif

  // Circular pointer arithmetic; DEPTH need not be a power of two.
  assign tos_inc    = (tos_q == PW'(DEPTH - 1)) ? '0 : tos_q + PW'(1);
  assign tos_dec    = (tos_q == '0) ? PW'(DEPTH - 1) : tos_q - PW'(1);
  assign stack_full = (cnt_q == NW'(DEPTH));
  assign ckpt_full  = (ckpt_cnt_q == (CW+1)'(NR_CKPT));

  // A release frees the head slot, which is what lets a checkpoint be
  // taken in the same cycle even when every slot is occupied.
  assign rel_ok   = release_i && (ckpt_cnt_q != '0);
  assign head_rel = head_q + (rel_ok ? CW'(1) : CW'(0));
  assign ckpt_ok  = ckpt_i && (!ckpt_full || rel_ok);

  // Next-state logic. Flush beats restore, and restore beats the normal
  // push/pop/checkpoint path. Release is honoured alongside restore so the
  // free count is measured from the already-advanced head.
  always_comb begin
    mem_d      = mem_q;
    tos_d      = tos_q;
    cnt_d      = cnt_q;
    slot_tos_d = slot_tos_q;
    slot_cnt_d = slot_cnt_q;
    slot_top_d = slot_top_q;
    head_d     = head_q;
    tail_d     = tail_q;
    ckpt_cnt_d = ckpt_cnt_q;
`ifdef RAS_CKPT_STATS_EN
    ovf_d      = ovf_q;
    unf_d      = unf_q;
`endif

    if (flush_i) begin
      tos_d      = '0;
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      ckpt_cnt_d = '0;
`ifdef RAS_CKPT_STATS_EN
      ovf_d      = '0;
      unf_d      = '0;
`endif
    end else if (restore_i) begin
      // The saved top value is written back because later pushes may have
      // overwritten that entry while the branch was speculative.
      tos_d                        = slot_tos_q[restore_id_i];
      cnt_d                        = slot_cnt_q[restore_id_i];
      mem_d[slot_tos_q[restore_id_i]] = slot_top_q[restore_id_i];
      head_d                       = head_rel;
      tail_d                       = restore_id_i;
      ckpt_cnt_d                   = {1'b0, restore_id_i - head_rel};
    end else begin
      if (push_i && pop_i) begin
        mem_d[tos_q] = data_i;
        if (cnt_q == '0) begin
          cnt_d = NW'(1);
        end
      end else if (push_i) begin
        tos_d          = tos_inc;
        mem_d[tos_inc] = data_i;
        if (!stack_full) begin
          cnt_d = cnt_q + NW'(1);
        end
`ifdef RAS_CKPT_STATS_EN
        else if (ovf_q != 16'hFFFF) begin
          ovf_d = ovf_q + 16'd1;
        end
`endif
      end else if (pop_i) begin
        if (cnt_q != '0) begin
          tos_d = tos_dec;
          cnt_d = cnt_q - NW'(1);
        end
`ifdef RAS_CKPT_STATS_EN
        else if (unf_q != 16'hFFFF) begin
          unf_d = unf_q + 16'd1;
        end
`endif
      end

      // Checkpoints capture the state as it was before this cycle's push/pop.
      if (ckpt_ok) begin
        slot_tos_d[tail_q] = tos_q;
        slot_cnt_d[tail_q] = cnt_q;
        slot_top_d[tail_q] = mem_q[tos_q];
        tail_d             = tail_q + CW'(1);
      end
      head_d     = head_rel;
      ckpt_cnt_d = ckpt_cnt_q + (ckpt_ok ? (CW+1)'(1) : (CW+1)'(0))
                              - (rel_ok  ? (CW+1)'(1) : (CW+1)'(0));
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q      <= '{default: '0};
      tos_q      <= '0;
      cnt_q      <= '0;
      slot_tos_q <= '{default: '0};
      slot_cnt_q <= '{default: '0};
      slot_top_q <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      ckpt_cnt_q <= '0;
`ifdef RAS_CKPT_STATS_EN
      ovf_q      <= '0;
      unf_q      <= '0;
`endif
    end else begin
      mem_q      <= mem_d;
      tos_q      <= tos_d;
      cnt_q      <= cnt_d;
      slot_tos_q <= slot_tos_d;
      slot_cnt_q <= slot_cnt_d;
      slot_top_q <= slot_top_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ckpt_cnt_q <= ckpt_cnt_d;
`ifdef RAS_CKPT_STATS_EN
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
`endif
    end
  end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Directed testbench for ras_ckpt_stack (DEPTH=2, VLEN=64, NR_CKPT=4).
// Inputs change 1 time unit after a rising edge, and outputs are
// checked at that same point, well away from the next active edge.
module tb_ras_ckpt_stack;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned VLEN    = 64;
  localparam int unsigned NR_CKPT = 4;
  localparam int unsigned CW      = $clog2(NR_CKPT);

  logic            clk_i;
  logic            rst_ni;
  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN-1:0] data_o;
  logic            valid_o;
  logic            ckpt_i;
  logic [CW-1:0]   ckpt_id_o;
  logic            ckpt_full_o;
  logic            restore_i;
  logic [CW-1:0]   restore_id_i;
  logic            release_i;
`ifdef RAS_CKPT_STATS_EN
  logic [15:0]     ovf_cnt_o;
  logic [15:0]     unf_cnt_o;
`endif

  int n_cmp;
  int n_fail;

  localparam logic [VLEN-1:0] VA = 64'hAAAA_0000_0000_1000;
  localparam logic [VLEN-1:0] VB = 64'hBBBB_0000_0000_2000;
  localparam logic [VLEN-1:0] VC = 64'hCCCC_0000_0000_3000;
  localparam logic [VLEN-1:0] VD = 64'hDDDD_0000_0000_4000;
  localparam logic [VLEN-1:0] VX = 64'h1234_5678_9ABC_DEF0;
  localparam logic [VLEN-1:0] VZ = 64'h0F0F_0F0F_0F0F_0F0F;

  ras_ckpt_stack #(
    .DEPTH   (DEPTH),
    .VLEN    (VLEN),
    .NR_CKPT (NR_CKPT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .pop_i        (pop_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ckpt_i       (ckpt_i),
    .ckpt_id_o    (ckpt_id_o),
    .ckpt_full_o  (ckpt_full_o),
`ifdef RAS_CKPT_STATS_EN
    .ovf_cnt_o    (ovf_cnt_o),
    .unf_cnt_o    (unf_cnt_o),
`endif
    .restore_i    (restore_i),
    .restore_id_i (restore_id_i),
    .release_i    (release_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle();
    flush_i      = 1'b0;
    push_i       = 1'b0;
    pop_i        = 1'b0;
    data_i       = '0;
    ckpt_i       = 1'b0;
    restore_i    = 1'b0;
    restore_id_i = '0;
    release_i    = 1'b0;
  endtask

  // Advance one clock with the current inputs applied, then return them to idle.
  task automatic step();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    step();
  endtask

  task automatic do_push(input logic [VLEN-1:0] v);
    push_i = 1'b1;
    data_i = v;
    step();
  endtask

  task automatic do_pop();
    pop_i = 1'b1;
    step();
  endtask

  task automatic do_ckpt();
    ckpt_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    n_cmp++; if (data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
    n_cmp++; if (ckpt_id_o !== '0) begin n_fail++; $display("[TB] FAIL reset_ckpt_id: got %0d expected 0", ckpt_id_o); end
    n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", ckpt_full_o); end
`ifdef RAS_CKPT_STATS_EN
    n_cmp++; if (ovf_cnt_o !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %0d expected 0", ovf_cnt_o); end
    n_cmp++; if (unf_cnt_o !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_unf: got %0d expected 0", unf_cnt_o); end
`endif
  endtask

  // Three pushes into a two-entry stack overwrite A; popping twice empties it.
  task automatic test_overflow();
    do_push(VA);
    do_push(VB);
    n_cmp++; if (data_o !== VB) begin n_fail++; $display("[TB] FAIL ovf_push_b: got %h expected %h", data_o, VB); end
    do_push(VC);
    n_cmp++; if (data_o !== VC) begin n_fail++; $display("[TB] FAIL ovf_push_c: got %h expected %h", data_o, VC); end
`ifdef RAS_CKPT_STATS_EN
    n_cmp++; if (ovf_cnt_o !== 16'd1) begin n_fail++; $display("[TB] FAIL ovf_cnt: got %0d expected 1", ovf_cnt_o); end
`endif
    do_pop();
    n_cmp++; if (data_o !== VB) begin n_fail++; $display("[TB] FAIL ovf_pop1_data: got %h expected %h", data_o, VB); end
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_pop1_valid: got %b expected 1", valid_o); end
    do_pop();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_pop2_valid: got %b expected 0", valid_o); end
  endtask

  // Stack is empty with tos=1 holding C: pop is ignored, push+pop fills it.
  task automatic test_underflow();
    do_pop();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL unf_valid: got %b expected 0", valid_o); end
    n_cmp++; if (data_o !== VC) begin n_fail++; $display("[TB] FAIL unf_data: got %h expected %h", data_o, VC); end
`ifdef RAS_CKPT_STATS_EN
    n_cmp++; if (unf_cnt_o !== 16'd1) begin n_fail++; $display("[TB] FAIL unf_cnt: got %0d expected 1", unf_cnt_o); end
`endif
    push_i = 1'b1;
    pop_i  = 1'b1;
    data_i = VD;
    step();
    n_cmp++; if (data_o !== VD) begin n_fail++; $display("[TB] FAIL pushpop_data: got %h expected %h", data_o, VD); end
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pushpop_valid: got %b expected 1", valid_o); end
    // Replacing the top leaves count at 1, so one pop empties the stack.
    do_pop();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL pushpop_count: got %b expected 0", valid_o); end
    do_flush();
`ifdef RAS_CKPT_STATS_EN
    n_cmp++; if (ovf_cnt_o !== 16'd0) begin n_fail++; $display("[TB] FAIL flush_ovf: got %0d expected 0", ovf_cnt_o); end
    n_cmp++; if (unf_cnt_o !== 16'd0) begin n_fail++; $display("[TB] FAIL flush_unf: got %0d expected 0", unf_cnt_o); end
`endif
  endtask

  task automatic test_ckpt_restore();
    do_push(VA);
    n_cmp++; if (ckpt_id_o !== 2'd0) begin n_fail++; $display("[TB] FAIL cr_id: got %0d expected 0", ckpt_id_o); end
    do_ckpt();
    n_cmp++; if (ckpt_id_o !== 2'd1) begin n_fail++; $display("[TB] FAIL cr_tail: got %0d expected 1", ckpt_id_o); end
    do_pop();
    do_push(VX);
    n_cmp++; if (data_o !== VX) begin n_fail++; $display("[TB] FAIL cr_spec_data: got %h expected %h", data_o, VX); end
    restore_i    = 1'b1;
    restore_id_i = 2'd0;
    step();
    n_cmp++; if (data_o !== VA) begin n_fail++; $display("[TB] FAIL cr_restored_data: got %h expected %h", data_o, VA); end
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL cr_restored_valid: got %b expected 1", valid_o); end
    n_cmp++; if (ckpt_id_o !== 2'd0) begin n_fail++; $display("[TB] FAIL cr_restored_tail: got %0d expected 0", ckpt_id_o); end
    n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL cr_restored_full: got %b expected 0", ckpt_full_o); end
    do_pop();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL cr_restored_count: got %b expected 0", valid_o); end
    do_flush();
  endtask

  task automatic test_ckpt_full();
    // Release with no live checkpoint must not disturb the count.
    release_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL full_early%0d: got %b expected 0", i, ckpt_full_o); end
      n_cmp++; if (ckpt_id_o !== CW'(i)) begin n_fail++; $display("[TB] FAIL full_id%0d: got %0d expected %0d", i, ckpt_id_o, i); end
      do_ckpt();
    end
    n_cmp++; if (ckpt_full_o !== 1'b1) begin n_fail++; $display("[TB] FAIL full_set: got %b expected 1", ckpt_full_o); end
    do_ckpt();
    n_cmp++; if (ckpt_id_o !== 2'd0) begin n_fail++; $display("[TB] FAIL full_ignored_id: got %0d expected 0", ckpt_id_o); end
    n_cmp++; if (ckpt_full_o !== 1'b1) begin n_fail++; $display("[TB] FAIL full_ignored_full: got %b expected 1", ckpt_full_o); end
    ckpt_i    = 1'b1;
    release_i = 1'b1;
    step();
    n_cmp++; if (ckpt_full_o !== 1'b1) begin n_fail++; $display("[TB] FAIL relckpt_full: got %b expected 1", ckpt_full_o); end
    n_cmp++; if (ckpt_id_o !== 2'd1) begin n_fail++; $display("[TB] FAIL relckpt_tail: got %0d expected 1", ckpt_id_o); end
    do_flush();
  endtask

  task automatic test_restore_push();
    do_push(VA);
    for (int i = 0; i < 3; i++) do_ckpt();
    push_i       = 1'b1;
    data_i       = VZ;
    restore_i    = 1'b1;
    restore_id_i = 2'd1;
    step();
    n_cmp++; if (data_o !== VA) begin n_fail++; $display("[TB] FAIL rp_push_discard: got %h expected %h", data_o, VA); end
    n_cmp++; if (ckpt_id_o !== 2'd1) begin n_fail++; $display("[TB] FAIL rp_tail: got %0d expected 1", ckpt_id_o); end
    release_i = 1'b1;
    step();
    // With every slot free again, exactly four more checkpoints fill the FIFO.
    for (int i = 0; i < 3; i++) do_ckpt();
    n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rp_after3: got %b expected 0", ckpt_full_o); end
    n_cmp++; if (ckpt_id_o !== 2'd0) begin n_fail++; $display("[TB] FAIL rp_after3_id: got %0d expected 0", ckpt_id_o); end
    do_ckpt();
    n_cmp++; if (ckpt_full_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rp_after4: got %b expected 1", ckpt_full_o); end
    do_flush();
  endtask

  task automatic test_release_restore();
    for (int i = 0; i < 3; i++) do_ckpt();
    release_i    = 1'b1;
    restore_i    = 1'b1;
    restore_id_i = 2'd2;
    step();
    // head=1, tail=2: one live checkpoint remains, so three more make it full.
    n_cmp++; if (ckpt_id_o !== 2'd2) begin n_fail++; $display("[TB] FAIL rr_tail: got %0d expected 2", ckpt_id_o); end
    do_ckpt();
    do_ckpt();
    n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_after2: got %b expected 0", ckpt_full_o); end
    do_ckpt();
    n_cmp++; if (ckpt_full_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_after3: got %b expected 1", ckpt_full_o); end
    do_flush();
  endtask

  task automatic test_flush_and_async_reset();
    do_push(VA);
    do_push(VB);
    for (int i = 0; i < 3; i++) do_ckpt();
    n_cmp++; if (ckpt_id_o !== 2'd3) begin n_fail++; $display("[TB] FAIL fl_pre_id: got %0d expected 3", ckpt_id_o); end
    do_flush();
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_valid: got %b expected 0", valid_o); end
    n_cmp++; if (data_o !== VB) begin n_fail++; $display("[TB] FAIL fl_data_kept: got %h expected %h", data_o, VB); end
    n_cmp++; if (ckpt_id_o !== 2'd0) begin n_fail++; $display("[TB] FAIL fl_id: got %0d expected 0", ckpt_id_o); end
    n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_full: got %b expected 0", ckpt_full_o); end

    do_push(VC);
    do_push(VD);
    for (int i = 0; i < 3; i++) do_ckpt();
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_pre_valid: got %b expected 1", valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (data_o !== '0) begin n_fail++; $display("[TB] FAIL ar_data: got %h expected 0", data_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_valid: got %b expected 0", valid_o); end
    n_cmp++; if (ckpt_id_o !== 2'd0) begin n_fail++; $display("[TB] FAIL ar_id: got %0d expected 0", ckpt_id_o); end
    n_cmp++; if (ckpt_full_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_full: got %b expected 0", ckpt_full_o); end
    #2;
    rst_ni = 1'b1;
    step();
    n_cmp++; if (data_o !== '0) begin n_fail++; $display("[TB] FAIL ar_post_data: got %h expected 0", data_o); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle();
    rst_ni = 1'b0;
    #12;
    rst_ni = 1'b1;
    step();

    test_reset();
    test_overflow();
    test_underflow();
    test_ckpt_restore();
    test_ckpt_full();
    test_restore_push();
    test_release_restore();
    test_flush_and_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
